// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - frame format shared by the UART transmitter and receiver
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchronizer, 3-sample majority vote and start detect
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic u_rx,
   input  logic idle,
   output logic bit_maj,
   output logic start_det
);

   logic       sync1;
   logic       sync2;
   logic [1:0] hist;
   logic       armed;

   // hist resets to 0 so the synchronizer's reset value of 1 cannot arm a line held low through reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= LINE_IDLE;
         sync2 <= LINE_IDLE;
         hist  <= 2'b00;
         armed <= 1'b0;
      end else begin
         sync1 <= u_rx;
         sync2 <= sync1;
         hist  <= {hist[0], sync2};
         if (idle && sync2 && (&hist))
            armed <= 1'b1;
      end
   end

   assign bit_maj   = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
   assign start_det = idle && armed && (sync2 == START_LVL);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART frame receiver with single-entry valid/ready output register
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 u_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   uart_state_t          state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 stop_q;
   logic                 done_q;
   logic                 bit_maj;
   logic                 start_det;
   logic                 tick;

   uart_rx_sampler u_sampler (
      .clk       (clk),
      .rst_n     (rst_n),
      .u_rx      (u_rx),
      .idle      (state == ST_IDLE),
      .bit_maj   (bit_maj),
      .start_det (start_det)
   );

   // the start bit is decided at its centre, every later bit one full bit time after the previous
   assign tick = (state == ST_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state != ST_IDLE)
            cnt <= tick ? '0 : cnt + CW'(1);
         case (state)
            ST_IDLE: begin
               if (start_det) begin
                  state <= ST_START;
                  cnt   <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (bit_maj != START_LVL) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_DATA;
                     idx   <= '0;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  shift_q[idx] <= bit_maj;
                  if (idx == IDX_LAST)
                     state <= ST_PARITY;
                  else
                     idx <= idx + IW'(1);
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  par_q <= bit_maj;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  stop_q <= bit_maj;
                  done_q <= 1'b1;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // a completed frame may replace a word that is being accepted in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done_q) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shift_q;
               parity_err <= par_q != even_parity(shift_q);
               frame_err  <= stop_q != STOP_LVL;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx
module tb_uart_rx;
   import uart_pkg::*;

   localparam int C = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       u_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_cyc = -1;
   int ovr_cnt = 0;
   int ovr_cyc = -1;
   logic prev_valid = 1'b0;

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       st;
      logic [7:0] ed;
      logic       ep;
      logic       ef;
   } vec_t;

   vec_t vecs[8];

   uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .u_rx       (u_rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (overrun) begin
         ovr_cnt = ovr_cnt + 1;
         ovr_cyc = cyc;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   // caller is at a negedge; each bit is held for C rising edges
   task automatic send_frame(input logic [7:0] d, input logic p, input logic st);
      logic [10:0] bits;
      bits = {st, p, d, 1'b0};
      for (int b = 0; b < 11; b++) begin
         u_rx = bits[b];
         repeat (C) @(negedge clk);
      end
   endtask

   task automatic consume(input string nm, input logic [7:0] ed);
      rx_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk({nm, " hold valid"}, int'(rx_valid), 1);
         chk({nm, " hold data"}, int'(rx_data), int'(ed));
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk({nm, " valid falls"}, int'(rx_valid), 0);
   endtask

   task automatic run_frame(input string nm, input logic [7:0] d, input logic p, input logic st,
                            input logic [7:0] ed, input logic ep, input logic ef);
      int t0;
      int o0;
      t0 = cyc + 1;
      o0 = ovr_cnt;
      send_frame(d, p, st);
      u_rx = 1'b1;
      repeat (2 * C) @(negedge clk);
      chk({nm, " valid time"}, rise_cyc, t0 + 171);
      chk({nm, " valid"}, int'(rx_valid), 1);
      chk({nm, " data"}, int'(rx_data), int'(ed));
      chk({nm, " parity_err"}, int'(parity_err), int'(ep));
      chk({nm, " frame_err"}, int'(frame_err), int'(ef));
      chk({nm, " no overrun"}, ovr_cnt - o0, 0);
      consume(nm, ed);
   endtask

   task automatic chk_cleared(input string nm);
      chk({nm, " rx_valid"}, int'(rx_valid), 0);
      chk({nm, " rx_data"}, int'(rx_data), 0);
      chk({nm, " parity_err"}, int'(parity_err), 0);
      chk({nm, " frame_err"}, int'(frame_err), 0);
      chk({nm, " overrun"}, int'(overrun), 0);
   endtask

   initial begin
      int k;
      int o0;

      vecs[0] = '{d: 8'hA5, p: 1'b0, st: 1'b1, ed: 8'hA5, ep: 1'b0, ef: 1'b0};
      vecs[1] = '{d: 8'h01, p: 1'b0, st: 1'b1, ed: 8'h01, ep: 1'b1, ef: 1'b0};
      vecs[2] = '{d: 8'h7E, p: 1'b0, st: 1'b0, ed: 8'h7E, ep: 1'b0, ef: 1'b1};
      vecs[3] = '{d: 8'h55, p: 1'b0, st: 1'b1, ed: 8'h55, ep: 1'b0, ef: 1'b0};
      vecs[4] = '{d: 8'hFF, p: 1'b0, st: 1'b1, ed: 8'hFF, ep: 1'b0, ef: 1'b0};
      vecs[5] = '{d: 8'h80, p: 1'b1, st: 1'b1, ed: 8'h80, ep: 1'b0, ef: 1'b0};
      vecs[6] = '{d: 8'h00, p: 1'b1, st: 1'b1, ed: 8'h00, ep: 1'b1, ef: 1'b0};
      vecs[7] = '{d: 8'h5A, p: 1'b1, st: 0,    ed: 8'h5A, ep: 1'b1, ef: 1'b1};

      rst_n    = 1'b0;
      u_rx     = 1'b1;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_cleared("reset");
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].st,
                   vecs[i].ed, vecs[i].ep, vecs[i].ef);

      // 3-cycle glitch must be rejected at the start-bit centre
      k = cyc;
      u_rx = 1'b0;
      repeat (3) @(negedge clk);
      u_rx = 1'b1;
      repeat (9) @(negedge clk);
      chk("glitch state idle", int'(dut.state), int'(ST_IDLE));
      chk("glitch at T0+2+H+1", cyc, k + 12);
      chk("glitch no valid", int'(rx_valid), 0);
      repeat (C) @(negedge clk);
      chk("glitch still no valid", int'(rx_valid), 0);
      run_frame("after glitch", 8'h33, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);

      // back-to-back with the register full: second frame dropped
      k  = cyc;
      o0 = ovr_cnt;
      send_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'hC3, 1'b0, 1'b1);
      u_rx = 1'b1;
      repeat (4) @(negedge clk);
      chk("ovr first valid time", rise_cyc, k + 172);
      chk("ovr pulse count", ovr_cnt - o0, 1);
      chk("ovr pulse time", ovr_cyc, k + 348);
      chk("ovr data kept", int'(rx_data), 8'h3C);
      chk("ovr valid kept", int'(rx_valid), 1);
      consume("ovr", 8'h3C);
      repeat (2 * C) @(negedge clk);

      // same pair, accepted exactly at the second completion edge
      k  = cyc;
      o0 = ovr_cnt;
      fork
         begin
            send_frame(8'h3C, 1'b0, 1'b1);
            send_frame(8'hC3, 1'b0, 1'b1);
            u_rx = 1'b1;
         end
         begin
            repeat (347) @(negedge clk);
            chk("accept-edge old data", int'(rx_data), 8'h3C);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            chk("accept-edge new data", int'(rx_data), 8'hC3);
            chk("accept-edge valid", int'(rx_valid), 1);
            chk("accept-edge no overrun", int'(overrun), 0);
         end
      join
      repeat (4) @(negedge clk);
      chk("accept-edge overrun count", ovr_cnt - o0, 0);
      consume("accept-edge", 8'hC3);
      repeat (2 * C) @(negedge clk);

      // reset mid-frame with the line held low through release
      send_frame(8'hE7, 1'b0, 1'b1);
      u_rx = 1'b1;
      repeat (2 * C) @(negedge clk);
      chk("pre-reset held data", int'(rx_data), 8'hE7);
      u_rx = 1'b0;
      repeat (40) @(negedge clk);
      chk("pre-reset in data", int'(dut.state), int'(ST_DATA));
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_cleared("mid reset");
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk_cleared("after reset low line");
      chk("after reset state idle", int'(dut.state), int'(ST_IDLE));
      u_rx = 1'b1;
      repeat (C) @(negedge clk);
      chk("after reset still empty", int'(rx_valid), 0);
      run_frame("after reset", 8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
